// File: rtl/decode_prefix_strip.sv
// Legacy-prefix / 0x0F-escape stripper ahead of operand decode.
// Walks one byte per cycle, then presents the 9 bytes from the opcode on.
module decode_prefix_strip #(
    parameter int MAX_PREFIXES = 4,
    parameter int WIN_BYTES    = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*WIN_BYTES-1:0]   in_instr,
    input  logic [3:0]               in_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [71:0]              unescaped_instr,
    output logic                     escaped,
    output logic                     prefix_operand_16bit,
    output logic                     prefix_address_16bit,
    output logic                     prefix_lock,
    output logic [1:0]               prefix_rep,
    output logic [2:0]               prefix_seg,
    output logic [3:0]               strip_len,
    output logic                     err
);

    typedef enum logic [1:0] {IDLE, WALK, EMIT} state_t;

    state_t                     state_q;
    logic [WIN_BYTES-1:0][7:0]  instr_q;
    logic [3:0]                 len_q, idx_q, npfx_q;
    logic                       in_ready_q, out_valid_q, escaped_q, op16_q, addr16_q, lock_q, err_q;
    logic [1:0]                 rep_q;
    logic [2:0]                 seg_q;
    logic [3:0]                 strip_q;
    logic [71:0]                unesc_q, win_d;

    logic [7:0] cur_b;
    logic       is_pfx, trunc, over, esc_b, walk_done, walk_err;
    logic [3:0] nidx;

    assign cur_b = (idx_q < 4'(WIN_BYTES)) ? instr_q[idx_q] : 8'h00;

    always_comb begin
        is_pfx = 1'b0;
        case (cur_b)
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3: is_pfx = 1'b1;
            default: is_pfx = 1'b0;
        endcase
    end

    // Truncation has priority over whatever stale byte sits at idx.
    assign trunc     = idx_q >= len_q;
    assign over      = !trunc && is_pfx && (npfx_q == 4'(MAX_PREFIXES));
    assign esc_b     = !trunc && (cur_b == 8'h0F);
    assign walk_err  = trunc || over;
    assign walk_done = walk_err || !is_pfx;
    assign nidx      = esc_b ? idx_q + 4'd1 : idx_q;

    always_comb begin
        logic [4:0] pos;
        win_d = '0;
        pos   = '0;
        for (int j = 0; j < 9; j++) begin
            pos = {1'b0, nidx} + 5'(j);
            if (pos < {1'b0, len_q})
                win_d[8*j +: 8] = instr_q[pos[3:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            npfx_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            unesc_q     <= '0;
            escaped_q   <= 1'b0;
            op16_q      <= 1'b0;
            addr16_q    <= 1'b0;
            lock_q      <= 1'b0;
            rep_q       <= 2'b00;
            seg_q       <= 3'd7;
            strip_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    instr_q    <= in_instr;
                    len_q      <= in_len;
                    idx_q      <= '0;
                    npfx_q     <= '0;
                    escaped_q  <= 1'b0;
                    op16_q     <= 1'b0;
                    addr16_q   <= 1'b0;
                    lock_q     <= 1'b0;
                    rep_q      <= 2'b00;
                    seg_q      <= 3'd7;
                    err_q      <= 1'b0;
                    in_ready_q <= 1'b0;
                    state_q    <= WALK;
                end
                WALK: if (walk_done) begin
                    idx_q       <= nidx;
                    strip_q     <= nidx;
                    escaped_q   <= esc_b;
                    err_q       <= walk_err;
                    unesc_q     <= walk_err ? 72'h0 : win_d;
                    out_valid_q <= 1'b1;
                    state_q     <= EMIT;
                end else begin
                    case (cur_b)
                        8'h26: seg_q <= 3'd0;
                        8'h2E: seg_q <= 3'd1;
                        8'h36: seg_q <= 3'd2;
                        8'h3E: seg_q <= 3'd3;
                        8'h64: seg_q <= 3'd4;
                        8'h65: seg_q <= 3'd5;
                        8'h66: op16_q   <= 1'b1;
                        8'h67: addr16_q <= 1'b1;
                        8'hF0: lock_q   <= 1'b1;
                        8'hF2: rep_q    <= 2'b10;
                        8'hF3: rep_q    <= 2'b11;
                        default: ;
                    endcase
                    npfx_q <= npfx_q + 4'd1;
                    idx_q  <= idx_q + 4'd1;
                end
                EMIT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready             = in_ready_q;
    assign out_valid            = out_valid_q;
    assign unescaped_instr      = unesc_q;
    assign escaped              = escaped_q;
    assign prefix_operand_16bit = op16_q;
    assign prefix_address_16bit = addr16_q;
    assign prefix_lock          = lock_q;
    assign prefix_rep           = rep_q;
    assign prefix_seg           = seg_q;
    assign strip_len            = strip_q;
    assign err                  = err_q;

endmodule

// File: tb/tb_decode_prefix_strip.sv
// Scoreboard bench for decode_prefix_strip: directed windows with hand-derived results.
module tb_decode_prefix_strip;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [119:0] in_instr = '0;
    logic [3:0]   in_len = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [71:0]  unescaped_instr;
    logic         escaped, prefix_operand_16bit, prefix_address_16bit, prefix_lock, err;
    logic [1:0]   prefix_rep;
    logic [2:0]   prefix_seg;
    logic [3:0]   strip_len;

    decode_prefix_strip dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_len(in_len), .out_valid(out_valid), .out_ready(out_ready),
        .unescaped_instr(unescaped_instr), .escaped(escaped),
        .prefix_operand_16bit(prefix_operand_16bit), .prefix_address_16bit(prefix_address_16bit),
        .prefix_lock(prefix_lock), .prefix_rep(prefix_rep), .prefix_seg(prefix_seg),
        .strip_len(strip_len), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] ui;
        logic        esc, o16, a16, lk, er;
        logic [1:0]  rep;
        logic [2:0]  seg;
        logic [3:0]  sl;
        bit          chk_sl;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Bytes at and beyond len are filled with 0xAA so zero-fill is exercised.
    task automatic send(input logic [119:0] win, input logic [3:0] len, input exp_t e);
        logic [119:0] w;
        int           n;
        w = win;
        for (int i = 0; i < 15; i++) if (i >= int'(len)) w[8*i +: 8] = 8'hAA;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("in_ready_timeout", 72'(in_ready), 72'd1);
        sb.push_back(e);
        in_instr = w;
        in_len   = len;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!out_valid) check({tag, "_timeout"}, 72'(out_valid), 72'd1);
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check({tag, "_instr"}, unescaped_instr, e.ui);
            check({tag, "_flags"}, 72'({escaped, prefix_operand_16bit, prefix_address_16bit, prefix_lock, err}),
                  72'({e.esc, e.o16, e.a16, e.lk, e.er}));
            check({tag, "_rep"}, 72'(prefix_rep), 72'(e.rep));
            check({tag, "_seg"}, 72'(prefix_seg), 72'(e.seg));
            if (e.chk_sl) check({tag, "_strip"}, 72'(strip_len), 72'(e.sl));
            if (h > 0) check({tag, "_held"}, 72'({out_valid, in_ready}), 72'b10);
        end
        if (!e.er && hold == 0) check({tag, "_lat"}, 72'(lat), 72'(e.lat));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    function automatic exp_t mk(logic [71:0] ui, logic esc, logic o16, logic a16, logic lk, logic er,
                                logic [1:0] rep, logic [2:0] seg, logic [3:0] sl, bit chk_sl, int lat);
        exp_t e;
        e.ui = ui; e.esc = esc; e.o16 = o16; e.a16 = a16; e.lk = lk; e.er = er;
        e.rep = rep; e.seg = seg; e.sl = sl; e.chk_sl = chk_sl; e.lat = lat;
        return e;
    endfunction

    initial begin
        int seen;
        #12;
        check("rst_ready_valid", 72'({in_ready, out_valid}), 72'b10);
        check("rst_seg", 72'(prefix_seg), 72'd7);
        check("rst_outs", 72'({unescaped_instr != 72'h0, escaped, err, strip_len}), 72'h0);
        @(negedge clk) rst_n = 1'b1;

        send(120'hD801, 4'd2, mk(72'hD801, 0, 0, 0, 0, 0, 2'b00, 3'd7, 4'd0, 1, 2));
        collect("plain", 0);
        send(120'hC1AF0FF36766, 4'd6, mk(72'hC1AF, 1, 1, 1, 0, 0, 2'b11, 3'd7, 4'd4, 1, 5));
        collect("esc_pfx", 0);
        send(120'hC089F3F2642E, 4'd6, mk(72'hC089, 0, 0, 0, 0, 0, 2'b11, 3'd4, 4'd4, 1, 6));
        collect("seg_rep", 0);
        send(120'h906666666666, 4'd6, mk(72'h0, 0, 1, 0, 0, 1, 2'b00, 3'd7, 4'd0, 0, 0));
        collect("too_many", 0);
        send(120'h6766, 4'd2, mk(72'h0, 0, 1, 1, 0, 1, 2'b00, 3'd7, 4'd2, 1, 0));
        collect("trunc", 0);
        send(120'h90, 4'd0, mk(72'h0, 0, 0, 0, 0, 1, 2'b00, 3'd7, 4'd0, 1, 0));
        collect("len0", 0);
        send(120'h0F0F653E26F0, 4'd6, mk(72'h0F, 1, 0, 0, 1, 0, 2'b00, 3'd5, 4'd5, 1, 6));
        collect("lock_gs", 0);
        send(120'h0E0D0C0B0A0908070605040302010F, 4'd15,
             mk(72'h090807060504030201, 1, 0, 0, 0, 0, 2'b00, 3'd7, 4'd1, 1, 2));
        collect("full_win", 0);
        send(120'h24048B67, 4'd4, mk(72'h24048B, 0, 0, 1, 0, 0, 2'b00, 3'd7, 4'd1, 1, 3));
        collect("zero_fill", 0);
        send(120'hC1AF0FF36766, 4'd6, mk(72'hC1AF, 1, 1, 1, 0, 0, 2'b11, 3'd7, 4'd4, 1, 5));
        collect("hold", 5);

        // Reset in the middle of a prefix walk: outputs drop at once, nothing emerges.
        send(120'h90F26766, 4'd4, mk(72'h0, 0, 0, 0, 0, 0, 2'b00, 3'd7, 4'd0, 0, 0));
        void'(sb.pop_back());
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ready_valid", 72'({in_ready, out_valid}), 72'b10);
        check("midrst_seg", 72'(prefix_seg), 72'd7);
        check("midrst_outs", 72'({unescaped_instr != 72'h0, escaped, prefix_operand_16bit,
                                  prefix_address_16bit, err, strip_len}), 72'h0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid) seen++; end
        check("midrst_no_output", 72'(seen), 72'd0);

        send(120'hD801, 4'd2, mk(72'hD801, 0, 0, 0, 0, 0, 2'b00, 3'd7, 4'd0, 1, 2));
        collect("after_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
